alu_issue_ctrl: RTL

Sequencing front end for the combinational ALU. It accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal 8-entry register file. It drives the ALU operand/opcode inputs, captures the ALU result, overflow and compare outputs, and writes results back. It also maintains the architectural flag register, and sits between the instruction source and the ALU in the core datapath.

---
 rtl/alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequencing front end for the combinational ALU.
//
// Accepts register-to-register instructions over a valid/ready handshake and
// reads operands from an 8-entry register file. It drives registered operands
// and opcode to the ALU, captures the ALU outputs one cycle later, and then
// writes back the result and updates the architectural flags.
//
// Pipeline per instruction: IDLE (accept) -> EXEC (ALU settles, capture) ->
// WB (done/err/trap pulse, writeback) -> IDLE. One instruction per 3 cycles.
//
// WORD_SIZE normally comes from top_macro.vh at the integrating level. Here it
// is exposed as a parameter so the block elaborates on its own.
//
// Optional feature, selected by macro ALU_CTRL_OVF_TRAP_EN:
//   defined   - an ADD/SUB whose captured overflow is set skips the register
//               write and pulses trap instead of done. ovf_flag is still set.
//   undefined - the result is always written, done always pulses, and trap
//               is tied to 0.
//
// Opcode encoding for the instructions this controller understands. Every
// other 5-bit value is illegal and completes with an err pulse:
//   ADD = 5'b00000, SUB = 5'b00001, CMP = 5'b00010
module alu_issue_ctrl #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  // Instruction handshake
  input  logic                 instr_valid,
  input  logic [15:0]          instr,
  output logic                 instr_ready,
  // External register load
  input  logic                 ld_en,
  input  logic [2:0]           ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  // Debug read port
  input  logic [2:0]           rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  // ALU interface
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [4:0]           alu_opcode,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_overflow,
  input  logic [1:0]           alu_comp_flag,
  // Completion
  output logic                 done,
  output logic [2:0]           done_rd,
  output logic [WORD_SIZE-1:0] done_result,
  output logic                 err,
  // Architectural flags
  output logic                 eq_flag,
  output logic                 gt_flag,
  output logic                 ovf_flag,
  output logic                 trap
);

  localparam int NREGS = 8;

  // Legal opcodes
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_CMP = 5'b00010;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0] state;

  // Instruction fields
  logic [4:0] f_opcode;
  logic [2:0] f_rd;
  logic [2:0] f_ra;
  logic [2:0] f_rb;
  logic       unused_instr_bits;

  assign f_opcode          = instr[15:11];
  assign f_rd              = instr[10:8];
  assign f_ra              = instr[7:5];
  assign f_rb              = instr[4:2];
  assign unused_instr_bits = ^instr[1:0];

  // Register file
  logic [WORD_SIZE-1:0] regs [NREGS];

  // Latched instruction and captured ALU outputs
  logic [4:0]           op_q;
  logic [2:0]           rd_q;
  logic [WORD_SIZE-1:0] res_q;
  logic                 ovf_q;
  logic [1:0]           comp_q;

  // Decode of the instruction currently in flight
  logic in_idle;
  logic in_exec;
  logic in_wb;
  logic is_arith;
  logic is_cmp;
  logic is_legal;
  logic accept;
  logic load_go;
  logic trap_hit;
  logic reg_wr;

  assign in_idle  = (state == ST_IDLE);
  assign in_exec  = (state == ST_EXEC);
  assign in_wb    = (state == ST_WB);

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_cmp   = (op_q == OP_CMP);
  assign is_legal = is_arith || is_cmp;

  // A pending load takes the idle cycle; the instruction waits one cycle.
  assign instr_ready = in_idle && !ld_en && !rst;
  assign accept      = instr_valid && instr_ready;
  assign load_go     = in_idle && ld_en;

`ifdef ALU_CTRL_OVF_TRAP_EN
  // Overflowing arithmetic traps instead of completing normally.
  assign trap_hit = in_wb && is_arith && ovf_q;
`else
  assign trap_hit = 1'b0;
`endif

  assign reg_wr = in_wb && is_arith && !trap_hit;

  // Completion outputs are only driven during WB; they read 0 otherwise.
  assign done        = in_wb && is_legal && !trap_hit;
  assign err         = in_wb && !is_legal;
  assign trap        = trap_hit;
  assign done_rd     = in_wb ? rd_q : 3'd0;
  assign done_result = (done && is_arith) ? res_q : '0;

  assign rd_data = regs[rd_addr];

  // State sequencing: IDLE -> EXEC -> WB -> IDLE; reset aborts any instruction.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_EXEC;
        ST_EXEC: state <= ST_WB;
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Latch the instruction and present operands to the ALU at accept; they
  // hold until the next accept, so the ALU inputs stay stable through WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 5'd0;
      rd_q       <= 3'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 5'd0;
    end else if (accept) begin
      op_q       <= f_opcode;
      rd_q       <= f_rd;
      alu_a      <= regs[f_ra];
      alu_b      <= regs[f_rb];
      alu_opcode <= f_opcode;
    end
  end

  // Capture the settled ALU outputs at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      ovf_q  <= 1'b0;
      comp_q <= 2'b00;
    end else if (in_exec) begin
      res_q  <= alu_c;
      ovf_q  <= alu_overflow;
      comp_q <= alu_comp_flag;
    end
  end

  // Register file: external loads in IDLE, arithmetic writeback in WB.
  // Operands were read at accept, so rd == ra/rb sees the pre-write value.
  always_ff @(posedge clk) begin
    // NOTE: the register file is cleared on reset because the architectural
    // state must read 0 after reset; this keeps it in flops, not a RAM macro.
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (load_go) begin
      regs[ld_addr] <= ld_data;
    end else if (reg_wr) begin
      regs[rd_q] <= res_q;
    end
  end

  // Architectural flags: ADD/SUB update ovf, CMP updates eq/gt; illegal
  // opcodes leave every flag untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_flag  <= 1'b0;
      gt_flag  <= 1'b0;
      ovf_flag <= 1'b0;
    end else if (in_wb) begin
      if (is_arith) begin
        ovf_flag <= ovf_q;
      end
      if (is_cmp) begin
        eq_flag <= comp_q[0];
        gt_flag <= comp_q[1];
      end
    end
  end

endmodule
